// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O bus sequencer and its arbiter.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } io_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } io_requester_e;

    localparam logic [15:0] IO_FLOAT_DATA = 16'hFFFF;

    // One requester's access fields, muxed as a unit into the bus registers.
    typedef struct packed {
        logic [19:1] addr;
        logic [15:0] data;
        logic        wr_en;
        logic [1:0]  bytesel;
    } io_req_t;

endpackage

// File: rtl/io_rr_arbiter.sv
// Two-way round-robin arbiter: the requester that did not win last time wins a tie.
module io_rr_arbiter
    import io_bus_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          dma_req,
    input  logic          grant_en,
    output logic          grant_valid,
    output io_requester_e grant
);

    io_requester_e rr_last;

    always_comb begin
        grant_valid = cpu_req | dma_req;
        if (cpu_req && dma_req) begin
            grant = (rr_last == REQ_DMA) ? REQ_CPU : REQ_DMA;
        end else if (dma_req) begin
            grant = REQ_DMA;
        end else begin
            grant = REQ_CPU;
        end
    end

    // Resetting to DMA makes the CPU win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= REQ_DMA;
        end else if (grant_en && grant_valid) begin
            rr_last <= grant;
        end
    end

endmodule

// File: rtl/io_bus_sequencer.sv
// Owns the shared 16-bit I/O bus: arbitrates CPU/DMA, runs one registered access,
// returns the selected device's ack and data, and times out dead or unmapped ports.
module io_bus_sequencer
    import io_bus_pkg::*;
#(
    parameter int          N_DEV          = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] FLOAT_DATA     = IO_FLOAT_DATA
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // Requester handshake: access is held high until the one-cycle io_ack;
    // data_in is valid with io_ack and held until the next ack to that requester.
    input  logic                  cpu_io_access,
    input  logic [19:1]           cpu_addr,
    input  logic [15:0]           cpu_data_out,
    input  logic                  cpu_wr_en,
    input  logic [1:0]            cpu_bytesel,
    output logic                  cpu_io_ack,
    output logic [15:0]           cpu_data_in,
    input  logic                  dma_io_access,
    input  logic [19:1]           dma_addr,
    input  logic [15:0]           dma_data_out,
    input  logic                  dma_wr_en,
    input  logic [1:0]            dma_bytesel,
    output logic                  dma_io_ack,
    output logic [15:0]           dma_data_in,
    output logic                  io_m_access,
    output logic [19:1]           io_m_addr,
    output logic [15:0]           io_m_data_out,
    output logic                  io_m_wr_en,
    output logic [1:0]            io_m_bytesel,
    input  logic [N_DEV-1:0]      dev_sel,
    input  logic [N_DEV-1:0]      dev_ack,
    input  logic [16*N_DEV-1:0]   dev_data,
    output logic                  timeout_err,
    output io_state_e             dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    io_state_e      state;
    io_requester_e  owner;
    io_requester_e  grant;
    logic           grant_valid;
    logic [TW-1:0]  timer;
    io_req_t        cpu_req_s;
    io_req_t        dma_req_s;
    io_req_t        win_req;
    logic [N_DEV-1:0] hits;
    logic           hit;
    logic [15:0]    hit_data;
    logic           finish;
    logic [15:0]    resp_data;

    io_rr_arbiter u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req     (cpu_io_access),
        .dma_req     (dma_io_access),
        .grant_en    (state == IDLE),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign cpu_req_s = {cpu_addr, cpu_data_out, cpu_wr_en, cpu_bytesel};
    assign dma_req_s = {dma_addr, dma_data_out, dma_wr_en, dma_bytesel};
    assign win_req   = (grant == REQ_DMA) ? dma_req_s : cpu_req_s;

    // Only a selected device's ack counts; the lowest-index acking slot wins.
    assign hits = dev_sel & dev_ack;
    assign hit  = |hits;

    always_comb begin
        hit_data = FLOAT_DATA;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_data = dev_data[16*i +: 16];
            end
        end
    end

    assign finish    = hit || (dev_sel == '0) || (timer == TIMER_LAST);
    assign resp_data = hit ? hit_data : FLOAT_DATA;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= REQ_CPU;
            timer         <= '0;
            io_m_access   <= 1'b0;
            io_m_addr     <= '0;
            io_m_data_out <= '0;
            io_m_wr_en    <= 1'b0;
            io_m_bytesel  <= '0;
            cpu_io_ack    <= 1'b0;
            cpu_data_in   <= '0;
            dma_io_ack    <= 1'b0;
            dma_data_in   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant;
                        io_m_access   <= 1'b1;
                        io_m_addr     <= win_req.addr;
                        io_m_data_out <= win_req.data;
                        io_m_wr_en    <= win_req.wr_en;
                        io_m_bytesel  <= win_req.bytesel;
                        timer         <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        // Timed-out writes are simply dropped; the requester is still acked.
                        io_m_access <= 1'b0;
                        timeout_err <= !hit;
                        state       <= RESP;
                        if (owner == REQ_DMA) begin
                            dma_io_ack  <= 1'b1;
                            dma_data_in <= resp_data;
                        end else begin
                            cpu_io_ack  <= 1'b1;
                            cpu_data_in <= resp_data;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    // Always pass through IDLE so devices see the strobe drop.
                    cpu_io_ack  <= 1'b0;
                    dma_io_ack  <= 1'b0;
                    timeout_err <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
